// File: rtl/sprite_blit.sv
// CHIP-8/SCHIP sprite engine: XOR-draws 8- or 16-pixel-wide sprites from main memory
// into a 1-bit VRAM shared with the display scanner, and clears the screen on request.
module sprite_blit #(
    parameter int XW     = 6,
    parameter int YW     = 5,
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cls,
    input  logic              wide,
    input  logic              wrap,
    input  logic [MEM_AW-1:0] I,
    input  logic [XW-1:0]     x,
    input  logic [YW-1:0]     y,
    input  logic [3:0]        n,
    output logic              busy,
    output logic              done,
    output logic              col,
    output logic [MEM_AW-1:0] mem_raddr,
    input  logic [7:0]        mem_d,
    output logic              vram_req,
    input  logic              vram_gnt,
    output logic [XW+YW-1:0]  vram_addr,
    output logic              vram_we,
    output logic              vram_wd,
    input  logic              vram_rd,
    output logic [2:0]        dbg_state_o
);
    // VRAM handshake: an access happens only in a cycle where vram_req and vram_gnt are both 1.
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH0, S_FETCH1, S_FETCH2, S_PIX_RD, S_PIX_WR, S_CLR, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [MEM_AW-1:0] base_q, base_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [4:0]        rows_q, rows_d, r_q, r_d;
    logic [3:0]        c_q, c_d;
    logic [15:0]       bits_q, bits_d;
    logic              wide_q, wide_d, wrap_q, wrap_d, col_q, col_d;
    logic [XW+YW-1:0]  clr_q, clr_d;

    logic              accept, clipped, last_pix, last_row;
    logic [4:0]        rows_in;
    logic [XW:0]       px_sum;
    logic [YW:0]       py_sum;
    logic [MEM_AW-1:0] row_base;
    logic [XW+YW-1:0]  pix_addr;

    assign accept   = (state_q == S_IDLE) && (start || cls);
    assign rows_in  = (wide && n == 4'd0) ? 5'd16 : {1'b0, n};
    // The extra top bit of each sum is the "ran off the edge" flag used for clipping.
    assign px_sum   = {1'b0, x_q} + (XW+1)'(c_q);
    assign py_sum   = {1'b0, y_q} + (YW+1)'(r_q);
    assign clipped  = !wrap_q && (px_sum[XW] || py_sum[YW]);
    assign pix_addr = {py_sum[YW-1:0], px_sum[XW-1:0]};
    assign last_pix = (c_q == (wide_q ? 4'd15 : 4'd7));
    assign last_row = ((r_q + 5'd1) == rows_q);
    assign row_base = base_q + (wide_q ? MEM_AW'({r_q, 1'b0}) : MEM_AW'(r_q));

    assign dbg_state_o = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0; x_q <= '0; y_q <= '0; rows_q <= '0; r_q <= '0; c_q <= '0;
            bits_q <= '0; wide_q <= 1'b0; wrap_q <= 1'b0; col_q <= 1'b0; clr_q <= '0;
        end else begin
            base_q <= base_d; x_q <= x_d; y_q <= y_d; rows_q <= rows_d; r_q <= r_d; c_q <= c_d;
            bits_q <= bits_d; wide_q <= wide_d; wrap_q <= wrap_d; col_q <= col_d; clr_q <= clr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cls)                         state_d = S_CLR;
                else if (start && rows_in == '0) state_d = S_DONE;
                else if (start)                  state_d = S_FETCH0;
            end
            S_FETCH0: state_d = S_FETCH1;
            S_FETCH1: state_d = wide_q ? S_FETCH2 : S_PIX_RD;
            S_FETCH2: state_d = S_PIX_RD;
            S_PIX_RD: if (vram_gnt) state_d = S_PIX_WR;
            S_PIX_WR: begin
                if (!vram_gnt || !last_pix) state_d = S_PIX_RD;
                else if (!last_row)         state_d = S_FETCH0;
                else                        state_d = S_DONE;
            end
            S_CLR:    if (vram_gnt && clr_q == '1) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        base_d = base_q; x_d = x_q; y_d = y_q; rows_d = rows_q; r_d = r_q; c_d = c_q;
        bits_d = bits_q; wide_d = wide_q; wrap_d = wrap_q; col_d = col_q; clr_d = clr_q;
        if (accept) begin
            base_d = I; x_d = x; y_d = y; rows_d = rows_in; wide_d = wide; wrap_d = wrap;
            r_d = '0; c_d = '0; col_d = 1'b0; clr_d = '0;
        end
        case (state_q)
            S_FETCH1: bits_d = {mem_d, 8'h00};
            S_FETCH2: bits_d = {bits_q[15:8], mem_d};
            S_PIX_WR: begin
                // Sprite bits shift out MSB-first, so bits_q[15] is always the current pixel.
                if (vram_gnt) begin
                    if (!clipped && bits_q[15] && vram_rd) col_d = 1'b1;
                    bits_d = {bits_q[14:0], 1'b0};
                    if (last_pix) begin
                        c_d = '0;
                        r_d = r_q + 5'd1;
                    end else begin
                        c_d = c_q + 4'd1;
                    end
                end
            end
            S_CLR:    if (vram_gnt) clr_d = clr_q + 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        col       = col_q;
        mem_raddr = '0;
        vram_req  = 1'b0;
        vram_addr = '0;
        vram_we   = 1'b0;
        vram_wd   = 1'b0;
        case (state_q)
            S_FETCH0: mem_raddr = row_base;
            S_FETCH1: mem_raddr = wide_q ? row_base + 1'b1 : row_base;
            S_FETCH2: mem_raddr = row_base + 1'b1;
            S_PIX_RD: begin
                vram_req  = 1'b1;
                vram_addr = pix_addr;
            end
            S_PIX_WR: begin
                vram_req  = 1'b1;
                vram_addr = pix_addr;
                vram_we   = vram_gnt && !clipped;
                vram_wd   = vram_rd ^ bits_q[15];
            end
            S_CLR: begin
                vram_req  = 1'b1;
                vram_addr = clr_q;
                vram_we   = vram_gnt;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/sprite_blit.md
Name: sprite_blit

Overview:
- Parametrised CHIP-8/SCHIP sprite engine that XOR-draws sprites from main memory into a 1-bit VRAM and reports pixel collision.
- Supports configurable screen size, 8x1..8x15 narrow and 16x16 wide sprites, wrap or clip at screen edges, and a clear-screen command.
- Sits between the CPU execute stage (DXYN/00E0) and the VRAM, sharing the VRAM port with the display scanner through a req/gnt pair.

Parameters:
- XW, 6, x coordinate width; screen width = 2**XW (6 -> 64, 7 -> 128).
- YW, 5, y coordinate width; screen height = 2**YW (5 -> 32, 6 -> 64).
- MEM_AW, 12, main memory address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  draw command; sampled only when busy=0
- cls  in  1  clear-screen command; sampled only when busy=0; has priority over start
- wide  in  1  1 = 16-pixel rows, 2 bytes per row
- wrap  in  1  1 = wrap pixels past the edges; 0 = clip them
- I  in  MEM_AW  sprite base address
- x  in  XW  start x
- y  in  YW  start y
- n  in  4  row count
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command end
- col  out  1  collision flag; valid from done until the next accepted command
- mem_raddr  out  MEM_AW  sprite memory read address
- mem_d  in  8  sprite memory data; 1-cycle read latency
- vram_req  out  1  VRAM port request
- vram_gnt  in  1  VRAM port grant
- vram_addr  out  XW+YW  VRAM address, {y,x}
- vram_we  out  1  VRAM write enable
- vram_wd  out  1  VRAM write data
- vram_rd  in  1  VRAM read data; 1-cycle read latency

Behaviour:
- Reset: state IDLE; busy, done, col, vram_req, vram_we, vram_wd = 0; mem_raddr = 0; vram_addr = 0. Reset mid-command aborts immediately and issues no further writes.
- Command accept (IDLE):
  - start or cls with busy=0 latches I, x, y, n, wide and wrap.
  - busy rises the next cycle. busy stays high through the DONE cycle.
  - Commands arriving while busy=1 are ignored.
- Row count:
  - Narrow: n rows; n=0 means no rows.
  - Wide: n=0 means 16 rows.
- States: IDLE, FETCH0, FETCH1, FETCH2, PIX_RD, PIX_WR, CLR, DONE.
- FETCH0: mem_raddr = I + r (narrow) or I + 2r (wide), where r is the row index.
- FETCH1: capture mem_d into the high byte; when wide, mem_raddr = previous + 1.
- FETCH2: wide only; capture mem_d into the low byte.
- Pixel order: bit 7 of the first byte is pixel 0 (leftmost). In wide mode, bits 7..0 of the second byte are pixels 8..15.
- Pixel coordinates:
  - px = x + c, py = y + r, with arithmetic modulo 2**XW and 2**YW.
  - Clip case: wrap=0 and the unwrapped sum is >= the screen dimension. The pixel is clipped.
- PIX_RD:
  - vram_req=1 and vram_addr={py,px}.
  - Advance to PIX_WR only when vram_gnt=1; otherwise hold.
- PIX_WR:
  - If vram_gnt=1 and the pixel is not clipped: vram_we=1, vram_wd = vram_rd ^ sprite bit.
  - If sprite bit=1 and vram_rd=1, set the col sticky bit.
  - If vram_gnt=0: no write, return to PIX_RD for the same pixel.
- Clipped pixels: they still take the PIX_RD/PIX_WR cycles (deterministic latency), with vram_we=0 and no collision.
- Next step after the last pixel: next row at FETCH0, or DONE after the last row.
- Latency with gnt held at 1: narrow = 18 cycles per row; wide = 35 cycles per row. The DONE cycle comes after that.
- CLR (cls):
  - Writes 0 to address 0 .. 2**(XW+YW)-1 in ascending order, one address per cycle while vram_gnt=1. The address stalls while gnt=0.
  - Then DONE. col=0.
- DONE: done=1 for one cycle; vram_req=0; state returns to IDLE.
- col: cleared on command accept, updated sticky during the draw, and holds its value after done.

Test Plan:
- Narrow draw, screen clear, gnt=1, I=0x050, mem[0x050]=0xF0, x=0, y=0, n=1 -> {0,0..3} written 1, {0,4..7} written 0, col=0, done 19 cycles after accept.
- Same draw repeated -> pixels 0..3 become 0, col=1.
- wrap=0, x=62 (XW=6), 0xFF, n=1 -> only x=62,63 written, no write at x=0..5, latency unchanged. With wrap=1 -> x=0..5 also written.
- Wide, n=0, all bytes 0xFF, XW=7, YW=6, empty screen -> 256 writes, all 1, done 16*35+1 cycles after accept, col=0.
- gnt dropped for 3 cycles while in PIX_WR -> no write that cycle, pixel re-read after gnt returns, final VRAM identical to the no-stall run.
- cls and start asserted together -> clear executes, 2**(XW+YW) zero writes, col=0. Then start while busy -> ignored. Then rst_n low mid-clear -> vram_we=0 immediately, busy=0.
